axi4_lite_slave_mem: RTL

Synthesizable, parametrised AXI4-Lite slave with a word-addressed register/memory array, used as the bus target behind the UART-AXI bridge in unit and system benches, and as an FPGA scratch register bank. Extends the single-transaction slave model with the following:
- independent AW/W acceptance in either order
- WSTRB byte-lane writes
- programmable wait states
- SLVERR on out-of-range addresses
- concurrent read and write channels

---
 rtl/axi4_lite_slave_mem_pkg.sv | 34 +++
 rtl/axi_wait_timer.sv | 51 +++++
 rtl/axi4_lite_slave_mem.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_slave_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_slave_mem_pkg
// Description : Shared response codes, channel FSM state types and the
//               address range helper for the AXI4-Lite slave memory.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_lite_slave_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_COLLECT = 2'd0,
    W_WAIT    = 2'd1,
    W_RESP    = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  // True when base <= addr < base + span. Arguments are widened to 64 bits
  // so the upper bound cannot wrap for any supported address width.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : axi_wait_timer
// Description : 4-bit load/countdown timer. Loading value N raises done for
//               exactly one cycle, N clock edges after the load edge.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               load         - load load_val and start counting
//               load_val     - number of edges to wait after the load edge
//               done         - one-cycle pulse when the count expires
// Revision    : 1.0 - initial release
// ============================================================================
module axi_wait_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] count_q, count_d;
  logic       running_q, running_d;

  always_comb begin
    count_d   = count_q;
    running_d = running_q;
    if (load) begin
      count_d   = load_val;
      running_d = 1'b1;
    end else if (running_q) begin
      if (count_q == 4'd0) begin
        running_d = 1'b0;
      end else begin
        count_d = count_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 4'd0;
      running_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      running_q <= running_d;
    end
  end

  assign done = running_q && (count_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/axi4_lite_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_slave_mem
// Description : AXI4-Lite slave backed by a word-addressed register array.
//               Independent write (AW/W in any order, byte strobes) and read
//               channels, programmable response wait states, SLVERR on
//               out-of-range addresses, write-done and error counters.
// Ports       : clk, rst_n                - clock, async active-low reset
//               aw*/w*/b*                 - AXI4-Lite write channels
//               ar*/r*                    - AXI4-Lite read channels
//               wr_done_count             - completed B handshakes (wraps)
//               err_count                 - SLVERR responses (saturates)
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_slave_mem
  import axi4_lite_slave_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_1000,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [15:0]               wr_done_count,
  output logic [15:0]               err_count
);

  localparam int          STRB_WIDTH = DATA_WIDTH / 8;
  localparam int          LSB        = $clog2(STRB_WIDTH);
  localparam int          IDX_W      = $clog2(DEPTH);
  localparam logic [63:0] SPAN       = 64'(DEPTH * STRB_WIDTH);
  // The read path waits WAIT_CYCLES edges after the AR edge before sampling;
  // the write path has already spent one edge on the commit, so it waits one
  // fewer (only used when WAIT_CYCLES > 0).
  localparam logic [3:0]  RD_LOAD    = 4'(WAIT_CYCLES);
  localparam logic [3:0]  WR_LOAD    = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  wr_state_t               wr_state_q, wr_state_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;

  rd_state_t               rd_state_q, rd_state_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [15:0]             wr_done_count_q, wr_done_count_d;
  logic [15:0]             err_count_q, err_count_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic                    wr_in_range, rd_in_range;
  logic [IDX_W-1:0]        wr_idx, rd_idx;

  assign wr_in_range = addr_in_range(64'(awaddr_q), 64'(BASE_ADDR), SPAN);
  assign rd_in_range = addr_in_range(64'(araddr_q), 64'(BASE_ADDR), SPAN);
  // Byte-offset bits are dropped; the index is only used when in range.
  assign wr_idx = IDX_W'((awaddr_q - BASE_ADDR) >> LSB);
  assign rd_idx = IDX_W'((araddr_q - BASE_ADDR) >> LSB);

  // --------------------------------------------------------------------------
  // Wait timers
  // --------------------------------------------------------------------------
  logic wr_timer_load, wr_timer_done;
  logic rd_timer_load, rd_timer_done;

  axi_wait_timer u_wr_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wr_timer_load),
    .load_val (WR_LOAD),
    .done     (wr_timer_done)
  );

  axi_wait_timer u_rd_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rd_timer_load),
    .load_val (RD_LOAD),
    .done     (rd_timer_done)
  );

  // --------------------------------------------------------------------------
  // Write channel FSM
  // --------------------------------------------------------------------------
  logic commit;
  logic b_hs;
  logic w_err;

  assign b_hs  = (wr_state_q == W_RESP) && bready;
  assign w_err = b_hs && (bresp_q == RESP_SLVERR);

  always_comb begin
    wr_state_d    = wr_state_q;
    aw_held_d     = aw_held_q;
    w_held_d      = w_held_q;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    commit        = 1'b0;
    wr_timer_load = 1'b0;

    case (wr_state_q)
      W_COLLECT: begin
        if (awvalid && awready_q) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end
        if (wvalid && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        // Both buffers were filled on earlier edges: commit on this edge.
        if (aw_held_q && w_held_q) begin
          commit  = 1'b1;
          bresp_d = wr_in_range ? RESP_OKAY : RESP_SLVERR;
          if (WAIT_CYCLES == 0) begin
            bvalid_d   = 1'b1;
            wr_state_d = W_RESP;
          end else begin
            wr_timer_load = 1'b1;
            wr_state_d    = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (wr_timer_done) begin
          bvalid_d   = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = W_COLLECT;
        end
      end
      default: begin
        wr_state_d = W_COLLECT;
      end
    endcase

    // Ready outputs are registered from the next-state view of the buffers.
    awready_d = (wr_state_d == W_COLLECT) && !aw_held_d;
    wready_d  = (wr_state_d == W_COLLECT) && !w_held_d;
  end

  // --------------------------------------------------------------------------
  // Read channel FSM
  // --------------------------------------------------------------------------
  logic r_err;

  assign r_err = (rd_state_q == R_RESP) && rready && (rresp_q == RESP_SLVERR);

  always_comb begin
    rd_state_d    = rd_state_q;
    araddr_d      = araddr_q;
    rvalid_d      = rvalid_q;
    rresp_d       = rresp_q;
    rdata_d       = rdata_q;
    rd_timer_load = 1'b0;

    case (rd_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          araddr_d      = araddr;
          rd_timer_load = 1'b1;
          rd_state_d    = R_WAIT;
        end
      end
      R_WAIT: begin
        // Sampling mem_q (not mem_d) returns pre-write data when a write
        // commits to the same word on this edge.
        if (rd_timer_done) begin
          rvalid_d   = 1'b1;
          rdata_d    = rd_in_range ? mem_q[rd_idx] : '0;
          rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: begin
        rd_state_d = R_IDLE;
      end
    endcase

    arready_d = (rd_state_d == R_IDLE);
  end

  // --------------------------------------------------------------------------
  // Memory array with byte-lane write enables
  // --------------------------------------------------------------------------
  always_comb begin
    mem_d = mem_q;
    if (commit && wr_in_range) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb_q[b]) begin
          mem_d[wr_idx][8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Counters: completed writes wrap, errors saturate (both channels may add)
  // --------------------------------------------------------------------------
  logic [16:0] err_sum;

  always_comb begin
    wr_done_count_d = wr_done_count_q + 16'(b_hs);
    err_sum         = {1'b0, err_count_q} + 17'(w_err) + 17'(r_err);
    err_count_d     = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q      <= W_COLLECT;
      aw_held_q       <= 1'b0;
      w_held_q        <= 1'b0;
      awaddr_q        <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      awready_q       <= 1'b1;
      wready_q        <= 1'b1;
      bvalid_q        <= 1'b0;
      bresp_q         <= RESP_OKAY;
      rd_state_q      <= R_IDLE;
      araddr_q        <= '0;
      arready_q       <= 1'b1;
      rvalid_q        <= 1'b0;
      rresp_q         <= RESP_OKAY;
      rdata_q         <= '0;
      wr_done_count_q <= 16'd0;
      err_count_q     <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_state_q      <= wr_state_d;
      aw_held_q       <= aw_held_d;
      w_held_q        <= w_held_d;
      awaddr_q        <= awaddr_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      awready_q       <= awready_d;
      wready_q        <= wready_d;
      bvalid_q        <= bvalid_d;
      bresp_q         <= bresp_d;
      rd_state_q      <= rd_state_d;
      araddr_q        <= araddr_d;
      arready_q       <= arready_d;
      rvalid_q        <= rvalid_d;
      rresp_q         <= rresp_d;
      rdata_q         <= rdata_d;
      wr_done_count_q <= wr_done_count_d;
      err_count_q     <= err_count_d;
      mem_q           <= mem_d;
    end
  end

  assign awready       = awready_q;
  assign wready        = wready_q;
  assign bvalid        = bvalid_q;
  assign bresp         = bresp_q;
  assign arready       = arready_q;
  assign rvalid        = rvalid_q;
  assign rresp         = rresp_q;
  assign rdata         = rdata_q;
  assign wr_done_count = wr_done_count_q;
  assign err_count     = err_count_q;

endmodule
`default_nettype wire
